pipeline_units_param: RTL
=========================

PIPELINE_UNITS_PARAM -- requirements
Module: pipeline_units_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width in bits, 1..256.
REQ-002 SHALL have parameter DEPTH, default 4: input buffer entries, 2..16.
REQ-003 SHALL have parameter STAGES, default 3: register stages from input to output, 1..8.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_flush  input  1  flush request from upstream.
REQ-007 inputs  input  WIDTH  upstream data.
REQ-008 in_valid  input  1  inputs valid this cycle.
REQ-009 in_stall  input  1  downstream cannot accept outputs.
REQ-010 outputs  output  WIDTH  last-stage data.
REQ-011 out_valid  output  1  outputs valid.
REQ-012 out_flush  output  1  registered flush indication to downstream.
REQ-013 out_stall  output  1  buffer full; upstream SHALL NOT present new data.
REQ-014 level  output  $clog2(DEPTH+1)  current buffer occupancy, 0..DEPTH.

Function
REQ-015 An input beat SHALL be accepted when in_valid=1, out_stall=0 and in_flush=0; in_valid=1 with out_stall=1 SHALL be dropped and SHALL leave the buffer unchanged.
REQ-016 Stage S (1..STAGES) SHALL hold valid bit v[S] and data d[S]; outputs=d[STAGES], out_valid=v[STAGES].
REQ-017 The last stage SHALL hold when in_stall=1 and v[STAGES]=1; otherwise it SHALL load from stage STAGES-1 (or from the stage-1 source when STAGES=1).
REQ-018 Stage S<STAGES SHALL advance when v[S+1]=0 or stage S+1 loads this cycle; a bubble SHALL be filled without waiting for a downstream stall to clear.
REQ-019 Stage-1 source: buffer head when level>0, else inputs (bypass); FIFO order SHALL be preserved across bypass and buffered beats.
REQ-020 An accepted beat SHALL be enqueued when level>0 or stage 1 cannot load this cycle; enqueue and dequeue in the same cycle SHALL leave level unchanged.
REQ-021 out_stall SHALL equal (level==DEPTH); a dequeue in a full cycle SHALL NOT permit a same-cycle enqueue.
REQ-022 Latency: with level=0 and no stall, a beat accepted at edge N SHALL appear on outputs with out_valid=1 after edge N+STAGES-1, i.e. STAGES cycles after presentation; throughput one beat per cycle.
REQ-023 A held output (in_stall=1, out_valid=1) SHALL keep outputs and out_valid constant.
REQ-024 in_flush=1 SHALL, at the next edge, clear all v[S], all d[S] to 0, level to 0, and drop any in_valid beat that cycle.
REQ-025 out_flush SHALL be 1 for each cycle following a cycle with in_flush=1, else 0.
REQ-026 Priority: reset > in_flush > in_stall > normal advance.
REQ-027 Buffer pointers SHALL wrap modulo DEPTH; DEPTH need not be a power of two.

Reset
REQ-028 reset=1 at an edge SHALL set outputs=0, out_valid=0, out_flush=0, out_stall=0, level=0, all stage and buffer state cleared.
REQ-029 Reset asserted mid-transfer SHALL discard all in-flight beats; no beat SHALL emerge after reset deasserts unless accepted afterwards.

Configuration
REQ-030 With PIPELINE_STALL_CNT_EN defined, the block SHALL add output stall_count (16 bits) counting cycles with in_stall=1 and out_valid=1, saturating at 16'hFFFF, cleared only by reset.
REQ-031 Without PIPELINE_STALL_CNT_EN, port stall_count and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Defaults; reset, then beats 0x11,0x22,0x33 on consecutive cycles, no stall -> outputs 0x11,0x22,0x33 on consecutive cycles, first 3 cycles after presentation; level stays 0.
REQ-033 Stream 0x1..0x8 with in_stall=1 from cycle 2 -> pipeline fills, level reaches 4, out_stall=1, further in_valid dropped; release stall -> 0x1.. in order, none lost or duplicated among accepted beats.
REQ-034 Buffer holding 3 beats, in_flush=1 for one cycle -> next cycle out_valid=0, outputs=0, level=0, out_flush=1; following cycle out_flush=0.
REQ-035 DEPTH=3, STAGES=1; 20 beats under random in_stall -> output order matches accepted order; pointer wrap exercised.
REQ-036 Reset asserted while level=2 and out_valid=1 -> next cycle all outputs 0; no pre-reset data appears afterwards.
REQ-037 PIPELINE_STALL_CNT_EN defined; hold in_stall=1 with out_valid=1 for 70000 cycles -> stall_count=16'hFFFF and stays there.

Source files
------------

// File: rtl/pipeline_units_param.sv
// Elastic register pipeline with an input FIFO buffer, flush and stall handling.
// Optional PIPELINE_STALL_CNT_EN adds a saturating stall_count output.
module pipeline_units_param #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 4,
    parameter int STAGES = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_flush,
    input  logic [WIDTH-1:0]           inputs,
    input  logic                       in_valid,
    input  logic                       in_stall,
    output logic [WIDTH-1:0]           outputs,
    output logic                       out_valid,
    output logic                       out_flush,
    output logic                       out_stall,
    output logic [$clog2(DEPTH+1)-1:0] level
`ifdef PIPELINE_STALL_CNT_EN
    ,
    output logic [15:0]                stall_count
`endif
);
    localparam int LW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);

    logic [STAGES:1]            r_v;
    logic [STAGES:1][WIDTH-1:0] r_d;
    logic [WIDTH-1:0]           r_buf [DEPTH];
    logic [PW-1:0]              r_rd;
    logic [PW-1:0]              r_wr;
    logic [LW-1:0]              r_level;
    logic                       r_flush;

    logic [STAGES:1]            w_load;
    logic                       w_run;
    logic [STAGES:1]            w_nxt_v;
    logic [STAGES:1][WIDTH-1:0] w_nxt_d;
    logic                       w_accept;
    logic                       w_buffered;
    logic                       w_src_v;
    logic [WIDTH-1:0]           w_src_d;
    logic                       w_enq;
    logic                       w_deq;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign outputs   = r_d[STAGES];
    assign out_valid = r_v[STAGES];
    assign out_flush = r_flush;
    assign out_stall = (r_level == LW'(DEPTH));
    assign level     = r_level;

    assign w_accept   = in_valid && !out_stall && !in_flush;
    assign w_buffered = (r_level != '0);
    assign w_src_v    = w_buffered || w_accept;
    assign w_src_d    = w_buffered ? r_buf[r_rd] : (w_accept ? inputs : '0);
    assign w_deq      = w_buffered && w_load[1];
    // Buffered beats go first, so a new beat bypasses only into an empty buffer.
    assign w_enq      = w_accept && (w_buffered || !w_load[1]);

    // A stage may load when it is empty or its content moves on this cycle.
    always_comb begin
        w_load = '0;
        w_run  = !r_v[STAGES] || !in_stall;
        w_load[STAGES] = w_run;
        for (int s = STAGES - 1; s >= 1; s--) begin
            w_run     = !r_v[s] || w_run;
            w_load[s] = w_run;
        end
    end

    always_comb begin
        w_nxt_v = r_v;
        w_nxt_d = r_d;
        if (w_load[1]) begin
            w_nxt_v[1] = w_src_v;
            w_nxt_d[1] = w_src_d;
        end
        for (int s = 2; s <= STAGES; s++) begin
            if (w_load[s]) begin
                w_nxt_v[s] = r_v[s-1];
                w_nxt_d[s] = r_d[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v     <= '0;
            r_d     <= '0;
            r_rd    <= '0;
            r_wr    <= '0;
            r_level <= '0;
            r_flush <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
        end else if (in_flush) begin
            r_v     <= '0;
            r_d     <= '0;
            r_rd    <= '0;
            r_wr    <= '0;
            r_level <= '0;
            r_flush <= 1'b1;
        end else begin
            r_flush <= 1'b0;
            r_v     <= w_nxt_v;
            r_d     <= w_nxt_d;
            if (w_enq) begin
                r_buf[r_wr] <= inputs;
                r_wr        <= f_inc(r_wr);
            end
            if (w_deq) r_rd <= f_inc(r_rd);
            case ({w_enq, w_deq})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

`ifdef PIPELINE_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    assign stall_count = r_stall_cnt;

    // Only reset clears the counter; flush leaves it alone.
    always_ff @(posedge clk) begin
        if (reset)
            r_stall_cnt <= '0;
        else if (in_stall && r_v[STAGES] && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end
`endif

endmodule
